// File: rtl/ifft_butterfly_5.sv
// rtl/ifft_butterfly_5.sv - pipelined radix-2 DIF inverse butterfly, optional Y clamp via IFFT_BF_SAT_EN
module ifft_butterfly_5 #(
    parameter int DW      = 12,
    parameter int TW      = 12,
    parameter int TW_FRAC = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           index,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_index,
    output logic signed [DW-1:0] x_re,
    output logic signed [DW-1:0] x_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im
);
    localparam int SW = DW + 1;
    localparam int PW = DW + TW + 2;
    localparam logic signed [PW-1:0] RND   = PW'(1 << TW_FRAC);
    localparam logic signed [PW-1:0] Y_MAX = PW'((1 << (DW - 1)) - 1);
    localparam logic signed [PW-1:0] Y_MIN = -PW'(1 << (DW - 1));

    logic                 adv;
    logic                 s1_valid;
    logic [2:0]           s1_index;
    logic signed [SW-1:0] s1_s_re, s1_s_im, s1_d_re, s1_d_im;
    logic signed [TW-1:0] s1_c, s1_sn;
    logic                 s2_valid;
    logic signed [TW-1:0] tw_c, tw_sn;
    logic signed [SW-1:0] xt_re, xt_im;
    logic signed [PW-1:0] p_re, p_im, r_re, r_im;
    logic signed [DW-1:0] yn_re, yn_im;

    // One advance signal moves every stage at once, so order is always preserved
    assign adv       = !s2_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = s2_valid;

    // Conjugate twiddle ROM: cos and +sin of 2*pi*k/16 in Q1.10
    always_comb begin
        tw_c  = TW'(1024);
        tw_sn = TW'(0);
        case (index)
            3'd0: begin tw_c = TW'(1024);  tw_sn = TW'(0);    end
            3'd1: begin tw_c = TW'(946);   tw_sn = TW'(392);  end
            3'd2: begin tw_c = TW'(724);   tw_sn = TW'(724);  end
            3'd3: begin tw_c = TW'(392);   tw_sn = TW'(946);  end
            3'd4: begin tw_c = TW'(0);     tw_sn = TW'(1024); end
            3'd5: begin tw_c = -TW'(392);  tw_sn = TW'(946);  end
            3'd6: begin tw_c = -TW'(724);  tw_sn = TW'(724);  end
            3'd7: begin tw_c = -TW'(946);  tw_sn = TW'(392);  end
            default: begin tw_c = TW'(1024); tw_sn = TW'(0); end
        endcase
    end

    // Stage 1: full-width sum/difference, index and twiddle captured with the beat
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_index <= '0;
            s1_s_re  <= '0;
            s1_s_im  <= '0;
            s1_d_re  <= '0;
            s1_d_im  <= '0;
            s1_c     <= '0;
            s1_sn    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_index <= index;
                s1_s_re  <= SW'(a_re) + SW'(b_re);
                s1_s_im  <= SW'(a_im) + SW'(b_im);
                s1_d_re  <= SW'(a_re) - SW'(b_re);
                s1_d_im  <= SW'(a_im) - SW'(b_im);
                s1_c     <= tw_c;
                s1_sn    <= tw_sn;
            end
        end
    end

    // Halving with round-half-up for X; complex multiply by conj(W) then round for Y
    always_comb begin
        xt_re = (s1_s_re + SW'(1)) >>> 1;
        xt_im = (s1_s_im + SW'(1)) >>> 1;
        p_re  = PW'(s1_d_re) * PW'(s1_c) - PW'(s1_d_im) * PW'(s1_sn);
        p_im  = PW'(s1_d_re) * PW'(s1_sn) + PW'(s1_d_im) * PW'(s1_c);
        r_re  = (p_re + RND) >>> (TW_FRAC + 1);
        r_im  = (p_im + RND) >>> (TW_FRAC + 1);
`ifdef IFFT_BF_SAT_EN
        yn_re = (r_re > Y_MAX) ? Y_MAX[DW-1:0] : (r_re < Y_MIN) ? Y_MIN[DW-1:0] : r_re[DW-1:0];
        yn_im = (r_im > Y_MAX) ? Y_MAX[DW-1:0] : (r_im < Y_MIN) ? Y_MIN[DW-1:0] : r_im[DW-1:0];
`else
        yn_re = r_re[DW-1:0];
        yn_im = r_im[DW-1:0];
`endif
    end

    // Stage 2: output registers, held while the downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_index <= '0;
            x_re      <= '0;
            x_im      <= '0;
            y_re      <= '0;
            y_im      <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_index <= s1_index;
                x_re      <= xt_re[DW-1:0];
                x_im      <= xt_im[DW-1:0];
                y_re      <= yn_re;
                y_im      <= yn_im;
            end
        end
    end

endmodule
